// File: rtl/rename_pkg.sv
// Shared types and constants for the two-wide register-rename stage.
// Holds the decoded and renamed instruction formats and the physical register sizing.
package rename_pkg;

  localparam int NUM_PREG = 64;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int AREG_W   = 5;

  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
    logic MemtoReg;
    logic Branch;
    logic ALUSrc;
  } ctrlStruct;

  typedef struct packed {
    logic [31:0]       pc;
    logic [6:0]        opcode;
    logic [AREG_W-1:0] rd;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    ctrlStruct         control;
  } instStruct;

  typedef struct packed {
    instStruct         inst;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
  } renStruct;

  // x0 is hardwired zero, so writes to it never claim a physical register.
  function automatic logic allocates(input instStruct i);
    return i.control.RegWrite && (i.rd != '0);
  endfunction

endpackage

// File: rtl/rename_if.sv
// Decode-to-dispatch rename port bundle, including the commit-side free ports.
// The master side is the decode/commit environment; the slave side is the rename stage.
interface rename_if;
  import rename_pkg::*;

  logic              dec_valid;
  instStruct         dec_ren_reg_a;
  instStruct         dec_ren_reg_b;
  logic              ren_stall;
  logic              free_en_a;
  logic              free_en_b;
  logic [PREG_W-1:0] free_preg_a;
  logic [PREG_W-1:0] free_preg_b;
  logic              ren_valid;
  renStruct          ren_dis_reg_a;
  renStruct          ren_dis_reg_b;

  modport master (
    output dec_valid, dec_ren_reg_a, dec_ren_reg_b,
    output free_en_a, free_en_b, free_preg_a, free_preg_b,
    input  ren_stall, ren_valid, ren_dis_reg_a, ren_dis_reg_b
  );

  modport slave (
    input  dec_valid, dec_ren_reg_a, dec_ren_reg_b,
    input  free_en_a, free_en_b, free_preg_a, free_preg_b,
    output ren_stall, ren_valid, ren_dis_reg_a, ren_dis_reg_b
  );

endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical registers: up to two pops and two pushes per cycle.
// Pushed registers become visible at the head only after the edge that writes them.
module free_list
  import rename_pkg::*;
#(
  parameter int FL_DEPTH  = 32,
  parameter int BASE_PREG = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                alloc_cnt,
  output logic [PREG_W-1:0]         fl_head0,
  output logic [PREG_W-1:0]         fl_head1,
  input  logic                      free_en_a,
  input  logic                      free_en_b,
  input  logic [PREG_W-1:0]         free_preg_a,
  input  logic [PREG_W-1:0]         free_preg_b,
  output logic [$clog2(FL_DEPTH):0] fl_count
);

  localparam int            PTR_W   = $clog2(FL_DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(FL_DEPTH);

  logic [PREG_W-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W-1:0]  tail_b;
  logic              push_a;
  logic              push_b;
  logic [1:0]        free_cnt;

  // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
    if (s >= DEPTH_V) s = s - DEPTH_V;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    push_a   = free_en_a && (free_preg_a != '0);
    push_b   = free_en_b && (free_preg_b != '0);
    free_cnt = {1'b0, push_a} + {1'b0, push_b};
    head_p1  = ptr_add(head, 2'd1);
    tail_b   = ptr_add(tail, {1'b0, push_a});
    fl_head0 = mem[head];
    fl_head1 = mem[head_p1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PREG_W'(BASE_PREG + i);
      end
      head     <= '0;
      tail     <= '0;
      fl_count <= DEPTH_V;
    end else begin
      if (push_a) mem[tail]   <= free_preg_a;
      if (push_b) mem[tail_b] <= free_preg_b;
      head     <= ptr_add(head, alloc_cnt);
      tail     <= ptr_add(tail, free_cnt);
      fl_count <= fl_count + (PTR_W+1)'(free_cnt) - (PTR_W+1)'(alloc_cnt);
    end
  end

  // Commit may never return more registers than the list can hold.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, fl_count} + {{PTR_W{1'b0}}, free_cnt}) <= (PTR_W+2)'(FL_DEPTH));

  underflow_chk: assert property (@(posedge clk) disable iff (rst)
    (PTR_W+1)'(alloc_cnt) <= fl_count);

endmodule

// File: rtl/rename.sv
// Two-wide rename stage: RAT lookup with intra-pair bypass, all-or-nothing allocation
// from the free list, and a registered renamed pair toward dispatch.
module rename
  import rename_pkg::*;
#(
  parameter int NUM_AREG = 32,
  parameter int FL_DEPTH = NUM_PREG - NUM_AREG
) (
  input logic     clk,
  input logic     rst,
  rename_if.slave rif
);

  localparam int CNT_W = $clog2(FL_DEPTH) + 1;

  logic [PREG_W-1:0] rat [NUM_AREG];
  logic [CNT_W-1:0]  fl_count;
  logic [PREG_W-1:0] fl_head0;
  logic [PREG_W-1:0] fl_head1;
  instStruct         inst_a;
  instStruct         inst_b;
  logic              alloc_a;
  logic              alloc_b;
  logic [1:0]        need;
  logic [1:0]        alloc_cnt;
  logic              stall;
  logic              fire;
  renStruct          ren_a;
  renStruct          ren_b;
  logic              ren_valid_q;
  renStruct          ren_a_q;
  renStruct          ren_b_q;

  free_list #(
    .FL_DEPTH  (FL_DEPTH),
    .BASE_PREG (NUM_AREG)
  ) u_free_list (
    .clk         (clk),
    .rst         (rst),
    .alloc_cnt   (alloc_cnt),
    .fl_head0    (fl_head0),
    .fl_head1    (fl_head1),
    .free_en_a   (rif.free_en_a),
    .free_en_b   (rif.free_en_b),
    .free_preg_a (rif.free_preg_a),
    .free_preg_b (rif.free_preg_b),
    .fl_count    (fl_count)
  );

  // Stall looks only at the registered count, so same-cycle frees cannot unblock a pair.
  always_comb begin
    inst_a    = rif.dec_ren_reg_a;
    inst_b    = rif.dec_ren_reg_b;
    alloc_a   = allocates(inst_a);
    alloc_b   = allocates(inst_b);
    need      = {1'b0, alloc_a} + {1'b0, alloc_b};
    stall     = rif.dec_valid && ((CNT_W)'(need) > fl_count);
    fire      = rif.dec_valid && !stall;
    alloc_cnt = fire ? need : 2'd0;
  end

  always_comb begin
    ren_a      = '0;
    ren_a.inst = inst_a;
    ren_a.prs1 = (inst_a.rs1 == '0) ? '0 : rat[inst_a.rs1];
    ren_a.prs2 = (inst_a.rs2 == '0) ? '0 : rat[inst_a.rs2];
    if (alloc_a) begin
      ren_a.prd     = fl_head0;
      ren_a.old_prd = rat[inst_a.rd];
    end
  end

  // The younger instruction sees the older one's new mapping through the bypass, not the RAT.
  always_comb begin
    ren_b      = '0;
    ren_b.inst = inst_b;
    if (alloc_a && (inst_b.rs1 == inst_a.rd)) ren_b.prs1 = ren_a.prd;
    else ren_b.prs1 = (inst_b.rs1 == '0) ? '0 : rat[inst_b.rs1];
    if (alloc_a && (inst_b.rs2 == inst_a.rd)) ren_b.prs2 = ren_a.prd;
    else ren_b.prs2 = (inst_b.rs2 == '0) ? '0 : rat[inst_b.rs2];
    if (alloc_b) begin
      ren_b.prd     = alloc_a ? fl_head1 : fl_head0;
      ren_b.old_prd = (alloc_a && (inst_b.rd == inst_a.rd)) ? ren_a.prd : rat[inst_b.rd];
    end
  end

  // When both write the same register the younger write lands last and wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat[i] <= PREG_W'(i);
      end
    end else if (fire) begin
      if (alloc_a) rat[inst_a.rd] <= ren_a.prd;
      if (alloc_b) rat[inst_b.rd] <= ren_b.prd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_valid_q <= 1'b0;
      ren_a_q     <= '0;
      ren_b_q     <= '0;
    end else begin
      ren_valid_q <= fire;
      if (fire) begin
        ren_a_q <= ren_a;
        ren_b_q <= ren_b;
      end
    end
  end

  assign rif.ren_stall     = stall;
  assign rif.ren_valid     = ren_valid_q;
  assign rif.ren_dis_reg_a = ren_a_q;
  assign rif.ren_dis_reg_b = ren_b_q;

endmodule

// File: tb/tb_rename.sv
// Directed bench for the rename stage: bypass, same-rd pairs, drain/stall, wrap and reset.
module tb_rename;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rename_if rif();

  rename dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
  );

  function automatic instStruct mk_inst(input int pc, input int rd, input int rs1, input int rs2,
                                        input logic reg_write, input logic mem_write);
    instStruct i;
    i                  = '0;
    i.pc               = 32'(pc);
    i.opcode           = mem_write ? 7'b0100011 : 7'b0110011;
    i.rd               = 5'(rd);
    i.rs1              = 5'(rs1);
    i.rs2              = 5'(rs2);
    i.control.RegWrite = reg_write;
    i.control.MemWrite = mem_write;
    return i;
  endfunction

  // Expected allocation order for the wrap run: reset image first, then the freed values in order.
  function automatic int wrap_free_val(input int k);
    return 1 + (k % 63);
  endfunction

  function automatic int wrap_alloc_val(input int n);
    return (n < 32) ? (32 + n) : wrap_free_val(n - 32);
  endfunction

  task automatic applyStimulus(input logic valid, input instStruct a, input instStruct b,
                               input logic fe_a, input int pa, input logic fe_b, input int pb);
    rif.dec_valid     = valid;
    rif.dec_ren_reg_a = a;
    rif.dec_ren_reg_b = b;
    rif.free_en_a     = fe_a;
    rif.free_preg_a   = PREG_W'(pa);
    rif.free_en_b     = fe_b;
    rif.free_preg_b   = PREG_W'(pb);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    checks++;
    assert (observed === 32'(expected)) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    instStruct ia;
    instStruct ib;
    instStruct st;

    st = mk_inst(200, 0, 1, 2, 1'b0, 1'b1);

    // Reset image
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(rif.ren_valid), 0);
    checkOutput("rst_a_prd", 32'(rif.ren_dis_reg_a.prd), 0);
    checkOutput("rst_b_old", 32'(rif.ren_dis_reg_b.old_prd), 0);
    checkOutput("rst_fl_count", 32'(dut.fl_count), 32);
    checkOutput("rst_stall", 32'(rif.ren_stall), 0);
    rst = 1'b0;

    // add x5,x1,x2 ; add x6,x5,x3
    applyStimulus(1'b1, mk_inst(100, 5, 1, 2, 1'b1, 1'b0), mk_inst(104, 6, 5, 3, 1'b1, 1'b0),
                  1'b0, 0, 1'b0, 0);
    checkOutput("t1_stall", 32'(rif.ren_stall), 0);
    checkOutput("t1_valid_before_edge", 32'(rif.ren_valid), 0);
    tick();
    checkOutput("t1_valid", 32'(rif.ren_valid), 1);
    checkOutput("t1_a_pc", rif.ren_dis_reg_a.inst.pc, 100);
    checkOutput("t1_a_prs1", 32'(rif.ren_dis_reg_a.prs1), 1);
    checkOutput("t1_a_prs2", 32'(rif.ren_dis_reg_a.prs2), 2);
    checkOutput("t1_a_prd", 32'(rif.ren_dis_reg_a.prd), 32);
    checkOutput("t1_a_old", 32'(rif.ren_dis_reg_a.old_prd), 5);
    checkOutput("t1_b_prs1_bypass", 32'(rif.ren_dis_reg_b.prs1), 32);
    checkOutput("t1_b_prs2", 32'(rif.ren_dis_reg_b.prs2), 3);
    checkOutput("t1_b_prd", 32'(rif.ren_dis_reg_b.prd), 33);
    checkOutput("t1_b_old", 32'(rif.ren_dis_reg_b.old_prd), 6);
    checkOutput("t1_fl_count", 32'(dut.fl_count), 30);
    applyStimulus(1'b0, '0, '0, 1'b0, 0, 1'b0, 0);
    tick();
    checkOutput("bubble_valid", 32'(rif.ren_valid), 0);
    checkOutput("bubble_hold_prd", 32'(rif.ren_dis_reg_a.prd), 32);
    checkOutput("bubble_fl_count", 32'(dut.fl_count), 30);

    // Both write x7, then a read of x7
    doReset();
    applyStimulus(1'b1, mk_inst(300, 7, 1, 2, 1'b1, 1'b0), mk_inst(304, 7, 7, 3, 1'b1, 1'b0),
                  1'b0, 0, 1'b0, 0);
    tick();
    checkOutput("t2_a_prd", 32'(rif.ren_dis_reg_a.prd), 32);
    checkOutput("t2_a_old", 32'(rif.ren_dis_reg_a.old_prd), 7);
    checkOutput("t2_b_prs1", 32'(rif.ren_dis_reg_b.prs1), 32);
    checkOutput("t2_b_prd", 32'(rif.ren_dis_reg_b.prd), 33);
    checkOutput("t2_b_old", 32'(rif.ren_dis_reg_b.old_prd), 32);
    applyStimulus(1'b1, mk_inst(308, 8, 7, 0, 1'b1, 1'b0), mk_inst(312, 0, 7, 8, 1'b0, 1'b1),
                  1'b0, 0, 1'b0, 0);
    tick();
    checkOutput("t2_x7_read", 32'(rif.ren_dis_reg_a.prs1), 33);
    checkOutput("t2_x0_read", 32'(rif.ren_dis_reg_a.prs2), 0);
    checkOutput("t2_next_prd", 32'(rif.ren_dis_reg_a.prd), 34);
    checkOutput("t2_st_prs1", 32'(rif.ren_dis_reg_b.prs1), 33);
    checkOutput("t2_st_prs2_bypass", 32'(rif.ren_dis_reg_b.prs2), 34);
    checkOutput("t2_st_prd", 32'(rif.ren_dis_reg_b.prd), 0);
    checkOutput("t2_st_old", 32'(rif.ren_dis_reg_b.old_prd), 0);
    checkOutput("t2_fl_count", 32'(dut.fl_count), 29);

    // Drain the free list with 16 allocating pairs
    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, mk_inst(400 + 8 * k, 10, 1, 2, 1'b1, 1'b0),
                    mk_inst(404 + 8 * k, 11, 3, 4, 1'b1, 1'b0), 1'b0, 0, 1'b0, 0);
      tick();
    end
    checkOutput("drain_a_prd", 32'(rif.ren_dis_reg_a.prd), 62);
    checkOutput("drain_b_prd", 32'(rif.ren_dis_reg_b.prd), 63);
    checkOutput("drain_fl_count", 32'(dut.fl_count), 0);

    // Store plus rd=x0 needs nothing and fires with an empty list
    applyStimulus(1'b1, st, mk_inst(500, 0, 1, 2, 1'b1, 1'b0), 1'b0, 0, 1'b0, 0);
    checkOutput("need0_stall", 32'(rif.ren_stall), 0);
    tick();
    checkOutput("need0_valid", 32'(rif.ren_valid), 1);
    checkOutput("need0_a_prd", 32'(rif.ren_dis_reg_a.prd), 0);
    checkOutput("need0_b_prd", 32'(rif.ren_dis_reg_b.prd), 0);
    checkOutput("need0_b_old", 32'(rif.ren_dis_reg_b.old_prd), 0);
    checkOutput("need0_fl_count", 32'(dut.fl_count), 0);

    // Empty list stalls even while p40 is being freed
    ia = mk_inst(600, 12, 1, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, ia, st, 1'b1, 40, 1'b0, 0);
    checkOutput("empty_stall", 32'(rif.ren_stall), 1);
    tick();
    checkOutput("empty_valid", 32'(rif.ren_valid), 0);
    checkOutput("free40_fl_count", 32'(dut.fl_count), 1);
    applyStimulus(1'b1, ia, st, 1'b0, 0, 1'b0, 0);
    checkOutput("free40_stall", 32'(rif.ren_stall), 0);
    tick();
    checkOutput("free40_valid", 32'(rif.ren_valid), 1);
    checkOutput("free40_a_prd", 32'(rif.ren_dis_reg_a.prd), 40);
    checkOutput("free40_a_old", 32'(rif.ren_dis_reg_a.old_prd), 12);
    checkOutput("free40_fl_count", 32'(dut.fl_count), 0);

    // Wrap: allocate two and free two every cycle
    doReset();
    ia = mk_inst(700, 13, 1, 2, 1'b1, 1'b0);
    ib = mk_inst(704, 14, 3, 4, 1'b1, 1'b0);
    applyStimulus(1'b1, ia, ib, 1'b0, 0, 1'b0, 0);
    tick();
    checkOutput("wrap0_a_prd", 32'(rif.ren_dis_reg_a.prd), wrap_alloc_val(0));
    checkOutput("wrap0_b_prd", 32'(rif.ren_dis_reg_b.prd), wrap_alloc_val(1));
    checkOutput("wrap0_fl_count", 32'(dut.fl_count), 30);
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1'b1, ia, ib, 1'b1, wrap_free_val(2 * (c - 1)),
                    1'b1, wrap_free_val(2 * (c - 1) + 1));
      tick();
      checkOutput("wrap_a_prd", 32'(rif.ren_dis_reg_a.prd), wrap_alloc_val(2 * c));
      checkOutput("wrap_b_prd", 32'(rif.ren_dis_reg_b.prd), wrap_alloc_val(2 * c + 1));
      checkOutput("wrap_fl_count", 32'(dut.fl_count), 30);
    end

    // Freeing p0 is ignored
    applyStimulus(1'b0, '0, '0, 1'b1, 0, 1'b1, 0);
    tick();
    checkOutput("free_p0_fl_count", 32'(dut.fl_count), 30);
    applyStimulus(1'b0, '0, '0, 1'b1, 0, 1'b1, 5);
    tick();
    checkOutput("free_p0_p5_fl_count", 32'(dut.fl_count), 31);

    // Reset in the middle of a stream
    applyStimulus(1'b1, ia, ib, 1'b0, 0, 1'b0, 0);
    tick();
    checkOutput("mid_valid", 32'(rif.ren_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(rif.ren_valid), 0);
    checkOutput("mid_rst_a_prd", 32'(rif.ren_dis_reg_a.prd), 0);
    checkOutput("mid_rst_fl_count", 32'(dut.fl_count), 32);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, mk_inst(800, 5, 13, 14, 1'b1, 1'b0), mk_inst(804, 6, 5, 0, 1'b1, 1'b0),
                  1'b0, 0, 1'b0, 0);
    tick();
    checkOutput("post_rst_a_prs1", 32'(rif.ren_dis_reg_a.prs1), 13);
    checkOutput("post_rst_a_prs2", 32'(rif.ren_dis_reg_a.prs2), 14);
    checkOutput("post_rst_a_prd", 32'(rif.ren_dis_reg_a.prd), 32);
    checkOutput("post_rst_a_old", 32'(rif.ren_dis_reg_a.old_prd), 5);
    checkOutput("post_rst_b_prs1", 32'(rif.ren_dis_reg_b.prs1), 32);
    checkOutput("post_rst_b_prd", 32'(rif.ren_dis_reg_b.prd), 33);
    checkOutput("post_rst_fl_count", 32'(dut.fl_count), 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
